// File: rtl/argmax_pkg.sv
// rtl/argmax_pkg.sv - shared FSM state encoding and default widths for the argmax stream block
package argmax_pkg;

   localparam int DEF_WIDTH = 64;
   localparam int DEF_IDX_W = 16;

   typedef enum logic [1:0] {
      FIRST = 2'd0,
      ACC   = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/gt_uint_nbit.sv
// rtl/gt_uint_nbit.sv - unsigned strict greater-than comparator (gt = a > b)
module gt_uint_nbit #(
   parameter int WIDTH     = 64,
   parameter int IMPL_TYPE = 0
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             gt
);

   generate
      if (IMPL_TYPE == 1) begin : g_borrow
         // b - a borrows out exactly when a > b
         logic [WIDTH:0] diff;
         assign diff = {1'b0, b} - {1'b0, a};
         assign gt   = diff[WIDTH];
      end else begin : g_direct
         assign gt = (a > b);
      end
   endgenerate

endmodule

// File: rtl/argmax_uint64_stream.sv
// rtl/argmax_uint64_stream.sv - per-frame maximum/index/count of an unsigned element stream
// Optional macro ARGMAX_TIE_LAST_EN: on equal values the latest index wins.
module argmax_uint64_stream
   import argmax_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int IDX_W     = DEF_IDX_W,
   parameter int IMPL_TYPE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_max,
   output logic [IDX_W-1:0] out_idx,
   output logic [IDX_W-1:0] out_cnt,
   output logic             out_ovf
);

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] max_r;
   logic [IDX_W-1:0] idx_r;
   logic [IDX_W-1:0] cnt_r;
   logic             ovf_r;
   logic [IDX_W-1:0] cnt_inc;
   logic             gt;
   logic             take;
   logic             in_fire;

   gt_uint_nbit #(
      .WIDTH     (WIDTH),
      .IMPL_TYPE (IMPL_TYPE)
   ) u_gt (
      .a  (in_data),
      .b  (max_r),
      .gt (gt)
   );

`ifdef ARGMAX_TIE_LAST_EN
   assign take = gt | (in_data == max_r);
`else
   assign take = gt;
`endif

   assign cnt_inc = cnt_r + IDX_W'(1);
   assign in_fire = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FIRST;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         FIRST, ACC: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = in_last ? DONE : ACC;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = FIRST;
            end
         end
         default: state_next = FIRST;
      endcase
   end

   // The element index equals the pre-increment count, so it wraps with cnt.
   always_ff @(posedge clk) begin
      if (rst) begin
         max_r <= '0;
         idx_r <= '0;
         cnt_r <= '0;
         ovf_r <= 1'b0;
      end else if (in_fire) begin
         if (state == FIRST) begin
            max_r <= in_data;
            idx_r <= '0;
            cnt_r <= IDX_W'(1);
            ovf_r <= 1'b0;
         end else begin
            if (take) begin
               max_r <= in_data;
               idx_r <= cnt_r;
            end
            cnt_r <= cnt_inc;
            if (cnt_inc == '0) begin
               ovf_r <= 1'b1;
            end
         end
      end
   end

   assign out_max = max_r;
   assign out_idx = idx_r;
   assign out_cnt = cnt_r;
   assign out_ovf = ovf_r;

endmodule

// File: tb/tb_argmax_uint64_stream.sv
// tb/tb_argmax_uint64_stream.sv - directed self-checking bench for argmax_uint64_stream
module tb_argmax_uint64_stream;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_max;
   logic [15:0] out_idx;
   logic [15:0] out_cnt;
   logic        out_ovf;

   logic        s_in_valid;
   logic        s_in_ready;
   logic [63:0] s_in_data;
   logic        s_in_last;
   logic        s_out_valid;
   logic        s_out_ready;
   logic [63:0] s_out_max;
   logic [3:0]  s_out_idx;
   logic [3:0]  s_out_cnt;
   logic        s_out_ovf;

   int errors = 0;
   int checks = 0;
   logic [63:0] exp_idx1;
   logic [63:0] held_max;

   always #5 clk = ~clk;

   argmax_uint64_stream u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_max   (out_max),
      .out_idx   (out_idx),
      .out_cnt   (out_cnt),
      .out_ovf   (out_ovf)
   );

   argmax_uint64_stream #(.IDX_W(4), .IMPL_TYPE(1)) u_small (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .in_data   (s_in_data),
      .in_last   (s_in_last),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .out_max   (s_out_max),
      .out_idx   (s_out_idx),
      .out_cnt   (s_out_cnt),
      .out_ovf   (s_out_ovf)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [63:0] d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      chk("in_ready_before_send", 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_small(input logic [63:0] d, input logic last);
      s_in_valid = 1'b1;
      s_in_data  = d;
      s_in_last  = last;
      step();
      s_in_valid = 1'b0;
      s_in_last  = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
      s_in_valid = 1'b0; s_in_data = '0; s_in_last = 1'b0; s_out_ready = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();

      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_max", out_max, 64'd0);
      chk("rst_out_idx", 64'(out_idx), 64'd0);
      chk("rst_out_cnt", 64'(out_cnt), 64'd0);
      chk("rst_out_ovf", 64'(out_ovf), 64'd0);

`ifdef ARGMAX_TIE_LAST_EN
      exp_idx1 = 64'd3;
`else
      exp_idx1 = 64'd1;
`endif
      send(64'd5, 1'b0);
      send(64'd9, 1'b0);
      send(64'd3, 1'b0);
      chk("f1_no_early_valid", 64'(out_valid), 64'd0);
      send(64'd9, 1'b1);
      chk("f1_valid", 64'(out_valid), 64'd1);
      chk("f1_in_ready_low", 64'(in_ready), 64'd0);
      chk("f1_max", out_max, 64'd9);
      chk("f1_idx", 64'(out_idx), exp_idx1);
      chk("f1_cnt", 64'(out_cnt), 64'd4);
      chk("f1_ovf", 64'(out_ovf), 64'd0);
      step();
      chk("f1_back_in_ready", 64'(in_ready), 64'd1);
      chk("f1_valid_drop", 64'(out_valid), 64'd0);

      out_ready = 1'b0;
      send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      chk("single_valid", 64'(out_valid), 64'd1);
      chk("single_max", out_max, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("single_idx", 64'(out_idx), 64'd0);
      chk("single_cnt", 64'(out_cnt), 64'd1);
      held_max = out_max;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("hold_valid", 64'(out_valid), 64'd1);
         chk("hold_in_ready", 64'(in_ready), 64'd0);
         chk("hold_max", out_max, held_max);
         chk("hold_cnt", 64'(out_cnt), 64'd1);
         chk("hold_idx", 64'(out_idx), 64'd0);
      end
      out_ready = 1'b1;
      step();
      chk("release_in_ready", 64'(in_ready), 64'd1);
      chk("release_valid", 64'(out_valid), 64'd0);

      send(64'h8000_0000_0000_0000, 1'b0);
      send(64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
      chk("unsigned_max", out_max, 64'h8000_0000_0000_0000);
      chk("unsigned_idx", 64'(out_idx), 64'd0);
      chk("unsigned_cnt", 64'(out_cnt), 64'd2);
      step();

      send(64'd100, 1'b0);
      send(64'd200, 1'b0);
      send(64'd300, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_valid", 64'(out_valid), 64'd0);
      chk("midrst_max", out_max, 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      send(64'd2, 1'b0);
      chk("midrst_no_early", 64'(out_valid), 64'd0);
      send(64'd1, 1'b1);
      chk("midrst_valid_end", 64'(out_valid), 64'd1);
      chk("midrst_max_end", out_max, 64'd2);
      chk("midrst_idx", 64'(out_idx), 64'd0);
      chk("midrst_cnt", 64'(out_cnt), 64'd2);
      step();

      for (int i = 0; i < 16; i++) begin
         send_small(64'(i % 7), 1'b0);
      end
      chk("ovf_no_early", 64'(s_out_valid), 64'd0);
      send_small(64'd7, 1'b1);
      chk("ovf_valid", 64'(s_out_valid), 64'd1);
      chk("ovf_max", s_out_max, 64'd7);
      chk("ovf_cnt", 64'(s_out_cnt), 64'd1);
      chk("ovf_idx", 64'(s_out_idx), 64'd0);
      chk("ovf_flag", 64'(s_out_ovf), 64'd1);
      step();
      send_small(64'd3, 1'b1);
      chk("ovf_cleared", 64'(s_out_ovf), 64'd0);
      chk("ovf_next_cnt", 64'(s_out_cnt), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
